// File: rtl/branch_ctrl_seq_pkg.sv
// Shared types and constants for the fetch + conditional-branch control sequencer.
package branch_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_T6   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    C2_ZR = 2'b00,
    C2_NZ = 2'b01,
    C2_PL = 2'b10,
    C2_MI = 2'b11
  } c2_e;

  localparam logic [5:0] ALU_ADD_DEF  = 6'd0;
  localparam logic [5:0] ALU_IDLE_DEF = 6'd13;
  localparam logic [4:0] OPC_BR_DEF   = 5'b10010;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic z_in;
    logic zlo_out;
    logic pc_in;
    logic busy;
  } strobes_t;

  function automatic logic branch_cond(input logic [1:0] c2, input logic is_zero,
                                       input logic sign_bit);
    logic res;
    case (c2_e'(c2))
      C2_ZR:   res = is_zero;
      C2_NZ:   res = !is_zero;
      C2_PL:   res = !sign_bit;
      C2_MI:   res = sign_bit;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_ctrl_seq_con_ff.sv
// CON flip-flop: decodes the C2 branch condition against the Ra value on the bus
// and captures the result whenever con_in_i is strobed.
module con_ff_logic
  import branch_ctrl_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              con_in_i,
  input  logic [1:0]        c2_i,
  input  logic [DATA_W-1:0] bus_i,
  output logic              con_ff_o
);

  logic cond_s;
  logic con_ff_q;

  always_comb begin
    cond_s = branch_cond(c2_i, (bus_i == '0), bus_i[DATA_W-1]);
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      con_ff_q <= 1'b0;
    end else if (con_in_i) begin
      con_ff_q <= cond_s;
    end else begin
      con_ff_q <= con_ff_q;
    end
  end

  assign con_ff_o = con_ff_q;

endmodule

// File: rtl/branch_ctrl_seq.sv
// Fetch + conditional-branch control sequencer: walks T0..T6, each STEP_CYCLES clocks long,
// and drives registered datapath strobes decoded from the next state.
module branch_ctrl_seq
  import branch_ctrl_seq_pkg::*;
#(
  parameter int                   DATA_W      = 32,
  parameter int                   REG_IDX_W   = 4,
  parameter int                   ALU_SEL_W   = 6,
  parameter logic [ALU_SEL_W-1:0] ALU_ADD     = ALU_SEL_W'(ALU_ADD_DEF),
  parameter logic [ALU_SEL_W-1:0] ALU_IDLE    = ALU_SEL_W'(ALU_IDLE_DEF),
  parameter logic [4:0]           OPC_BR      = OPC_BR_DEF,
  parameter int                   STEP_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 clr,
  input  logic                 start,
  input  logic [DATA_W-1:0]    ir,
  input  logic [DATA_W-1:0]    bus_in,
  output logic                 pc_out,
  output logic                 mar_in,
  output logic                 inc_pc,
  output logic                 read,
  output logic                 mdr_in,
  output logic                 mdr_out,
  output logic                 ir_in,
  output logic [REG_IDX_W-1:0] gra,
  output logic                 r_out,
  output logic                 con_in,
  output logic                 y_in,
  output logic                 c_out,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 z_in,
  output logic                 zlo_out,
  output logic                 pc_in,
  output logic                 con_ff,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  // A one-cycle step still needs a 1-bit counter; it simply never leaves zero.
  localparam int              CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  strobes_t              stb_q, stb_d;
  logic [REG_IDX_W-1:0]  gra_q, gra_d;
  logic [ALU_SEL_W-1:0]  alu_q, alu_d;
  logic                  done_q, done_d;
  logic                  illegal_q, illegal_d;
  logic                  last_s, last_d_s, opc_ok_s, con_ff_s;
  logic                  ir_unused_s;

  assign opc_ok_s    = (ir[DATA_W-1 -: 5] == OPC_BR);
  assign ir_unused_s = ^{ir[22:21], ir[18:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    last_s    = (cnt_q == CNT_LAST);
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_T0;
        cnt_d   = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (last_s) begin
      cnt_d = '0;
      case (state_q)
        ST_T0: state_d = ST_T1;
        ST_T1: state_d = ST_T2;
        // Opcode is checked as T3 would be entered, so a bad IR never shows T3 strobes.
        ST_T2: begin
          if (opc_ok_s) begin
            state_d = ST_T3;
          end else begin
            state_d   = ST_IDLE;
            illegal_d = 1'b1;
          end
        end
        ST_T3: state_d = ST_T4;
        ST_T4: state_d = ST_T5;
        ST_T5: state_d = ST_T6;
        ST_T6: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    stb_d      = '0;
    gra_d      = '0;
    alu_d      = ALU_IDLE;
    last_d_s   = (cnt_d == CNT_LAST);
    stb_d.busy = (state_d != ST_IDLE);
    case (state_d)
      ST_T0: begin
        stb_d.pc_out = 1'b1;
        stb_d.mar_in = 1'b1;
        stb_d.inc_pc = last_d_s;
      end
      ST_T1: begin
        stb_d.read   = 1'b1;
        stb_d.mdr_in = 1'b1;
      end
      ST_T2: begin
        stb_d.mdr_out = 1'b1;
        stb_d.ir_in   = 1'b1;
      end
      ST_T3: begin
        gra_d        = ir[23 +: REG_IDX_W];
        stb_d.r_out  = 1'b1;
        stb_d.con_in = last_d_s;
      end
      ST_T4: begin
        stb_d.pc_out = 1'b1;
        stb_d.y_in   = 1'b1;
      end
      ST_T5: begin
        stb_d.c_out = 1'b1;
        stb_d.z_in  = 1'b1;
        alu_d       = ALU_ADD;
      end
      ST_T6: begin
        if (con_ff_s) begin
          stb_d.zlo_out = 1'b1;
          stb_d.pc_in   = 1'b1;
        end else begin
          stb_d.zlo_out = 1'b0;
        end
      end
      default: stb_d.busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stb_q     <= '0;
      gra_q     <= '0;
      alu_q     <= ALU_IDLE;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      gra_q     <= gra_d;
      alu_q     <= alu_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  con_ff_logic #(.DATA_W(DATA_W)) u_con_ff (
    .clock    (clock),
    .clr      (clr),
    .con_in_i (stb_q.con_in),
    .c2_i     (ir[20:19]),
    .bus_i    (bus_in),
    .con_ff_o (con_ff_s)
  );

  assign pc_out  = stb_q.pc_out;
  assign mar_in  = stb_q.mar_in;
  assign inc_pc  = stb_q.inc_pc;
  assign read    = stb_q.read;
  assign mdr_in  = stb_q.mdr_in;
  assign mdr_out = stb_q.mdr_out;
  assign ir_in   = stb_q.ir_in;
  assign r_out   = stb_q.r_out;
  assign con_in  = stb_q.con_in;
  assign y_in    = stb_q.y_in;
  assign c_out   = stb_q.c_out;
  assign z_in    = stb_q.z_in;
  assign zlo_out = stb_q.zlo_out;
  assign pc_in   = stb_q.pc_in;
  assign busy    = stb_q.busy;
  assign gra     = gra_q;
  assign alu_sel = alu_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign con_ff  = con_ff_s;

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Bench for branch_ctrl_seq: a cycle-position model predicts every output of two instances
// (STEP_CYCLES=4 and STEP_CYCLES=1), and directed runs pin the model with literal expectations.
module tb_branch_ctrl_seq;

  logic        clock = 1'b0;
  logic        clr = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] ir = 32'd0;
  logic [31:0] bus_in = 32'd0;

  logic a_pc_out, a_mar_in, a_inc_pc, a_read, a_mdr_in, a_mdr_out, a_ir_in, a_r_out;
  logic a_con_in, a_y_in, a_c_out, a_z_in, a_zlo_out, a_pc_in, a_con_ff, a_busy, a_done, a_illegal;
  logic [3:0] a_gra;
  logic [5:0] a_alu;
  logic b_pc_out, b_mar_in, b_inc_pc, b_read, b_mdr_in, b_mdr_out, b_ir_in, b_r_out;
  logic b_con_in, b_y_in, b_c_out, b_z_in, b_zlo_out, b_pc_in, b_con_ff, b_busy, b_done, b_illegal;
  logic [3:0] b_gra;
  logic [5:0] b_alu;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  branch_ctrl_seq #(.STEP_CYCLES(4)) dut_a (
    .clock(clock), .clr(clr), .start(start_a), .ir(ir), .bus_in(bus_in),
    .pc_out(a_pc_out), .mar_in(a_mar_in), .inc_pc(a_inc_pc), .read(a_read),
    .mdr_in(a_mdr_in), .mdr_out(a_mdr_out), .ir_in(a_ir_in), .gra(a_gra),
    .r_out(a_r_out), .con_in(a_con_in), .y_in(a_y_in), .c_out(a_c_out),
    .alu_sel(a_alu), .z_in(a_z_in), .zlo_out(a_zlo_out), .pc_in(a_pc_in),
    .con_ff(a_con_ff), .busy(a_busy), .done(a_done), .illegal(a_illegal)
  );

  branch_ctrl_seq #(.STEP_CYCLES(1)) dut_b (
    .clock(clock), .clr(clr), .start(start_b), .ir(ir), .bus_in(bus_in),
    .pc_out(b_pc_out), .mar_in(b_mar_in), .inc_pc(b_inc_pc), .read(b_read),
    .mdr_in(b_mdr_in), .mdr_out(b_mdr_out), .ir_in(b_ir_in), .gra(b_gra),
    .r_out(b_r_out), .con_in(b_con_in), .y_in(b_y_in), .c_out(b_c_out),
    .alu_sel(b_alu), .z_in(b_z_in), .zlo_out(b_zlo_out), .pc_in(b_pc_in),
    .con_ff(b_con_ff), .busy(b_busy), .done(b_done), .illegal(b_illegal)
  );

  logic [27:0] vec_a, vec_b;
  assign vec_a = {a_pc_out, a_mar_in, a_inc_pc, a_read, a_mdr_in, a_mdr_out, a_ir_in, a_r_out,
                  a_con_in, a_y_in, a_c_out, a_z_in, a_zlo_out, a_pc_in,
                  a_busy, a_done, a_illegal, a_con_ff, a_gra, a_alu};
  assign vec_b = {b_pc_out, b_mar_in, b_inc_pc, b_read, b_mdr_in, b_mdr_out, b_ir_in, b_r_out,
                  b_con_in, b_y_in, b_c_out, b_z_in, b_zlo_out, b_pc_in,
                  b_busy, b_done, b_illegal, b_con_ff, b_gra, b_alu};

  function automatic bit take_branch(input logic [31:0] irv, input logic [31:0] busv);
    case (irv[20:19])
      2'b00:   return busv == 32'd0;
      2'b01:   return busv != 32'd0;
      2'b10:   return busv[31] == 1'b0;
      default: return busv[31] == 1'b1;
    endcase
  endfunction

  // Expected outputs from position k (clocks since the start edge) within a 7-step sequence.
  function automatic logic [27:0] exp_vec(input bit act, input int k, input int s,
                                          input logic [31:0] irv, input bit con,
                                          input bit dn, input bit il);
    logic [13:0] st;
    logic [3:0]  g;
    logic [5:0]  a;
    bit          last;
    st = 14'd0;
    g  = 4'd0;
    a  = 6'd13;
    if (act) begin
      last = ((k % s) == s - 1);
      case (k / s)
        0: begin st[13] = 1'b1; st[12] = 1'b1; st[11] = last; end
        1: begin st[10] = 1'b1; st[9] = 1'b1; end
        2: begin st[8] = 1'b1; st[7] = 1'b1; end
        3: begin g = irv[26:23]; st[6] = 1'b1; st[5] = last; end
        4: begin st[13] = 1'b1; st[4] = 1'b1; end
        5: begin st[3] = 1'b1; st[2] = 1'b1; a = 6'd0; end
        6: begin st[1] = con; st[0] = con; end
        default: ;
      endcase
    end
    return {st, act, dn, il, con, g, a};
  endfunction

  bit act_m[2];
  int k_m[2];
  bit con_m[2];
  bit done_m[2];
  bit il_m[2];
  int step_m[2] = '{4, 1};

  // Model progression: index 0 tracks dut_a, index 1 tracks dut_b.
  always @(posedge clock or negedge clr) begin
    for (int d = 0; d < 2; d++) begin
      if (!clr) begin
        act_m[d]  <= 1'b0;
        k_m[d]    <= 0;
        con_m[d]  <= 1'b0;
        done_m[d] <= 1'b0;
        il_m[d]   <= 1'b0;
      end else begin
        done_m[d] <= 1'b0;
        il_m[d]   <= 1'b0;
        if (act_m[d]) begin
          if (k_m[d] + 1 == 3 * step_m[d] && ir[31:27] != 5'b10010) begin
            act_m[d] <= 1'b0;
            il_m[d]  <= 1'b1;
          end else if (k_m[d] + 1 == 7 * step_m[d]) begin
            act_m[d]  <= 1'b0;
            done_m[d] <= 1'b1;
          end else begin
            k_m[d] <= k_m[d] + 1;
          end
          if (k_m[d] + 1 == 4 * step_m[d]) con_m[d] <= take_branch(ir, bus_in);
        end else if ((d == 0) ? start_a : start_b) begin
          act_m[d] <= 1'b1;
          k_m[d]   <= 0;
        end
      end
    end
  end

  task automatic chk_vec(input string name, input logic [27:0] got, input logic [27:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Single compare process: every output of both instances against the model, each cycle.
  always @(negedge clock) begin
    chk_vec("dut_a_outputs", vec_a,
            exp_vec(act_m[0], k_m[0], step_m[0], ir, con_m[0], done_m[0], il_m[0]));
    chk_vec("dut_b_outputs", vec_b,
            exp_vec(act_m[1], k_m[1], step_m[1], ir, con_m[1], done_m[1], il_m[1]));
  end

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [1:0] c2);
    return {opc, ra, 2'b00, c2, 19'd0};
  endfunction

  task automatic run_a(input logic [31:0] irv, input logic [31:0] busv, input int ncyc,
                       output int done_n, output int ill_n, output int zlo_cnt,
                       output int inc_cnt, output int rout_cnt);
    done_n = -1; ill_n = -1; zlo_cnt = 0; inc_cnt = 0; rout_cnt = 0;
    ir = irv;
    bus_in = busv;
    @(negedge clock);
    start_a = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clock);
      start_a = 1'b0;
      if (a_done && done_n < 0) done_n = n;
      if (a_illegal && ill_n < 0) ill_n = n;
      zlo_cnt  += int'(a_zlo_out & a_pc_in);
      inc_cnt  += int'(a_inc_pc);
      rout_cnt += int'(a_r_out);
    end
  endtask

  initial begin
    int dn, il, zc, ic, rc, dcnt;
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, il, zc, ic, rc, dcnt, icnt, first_done;
    repeat (3) @(negedge clock);
    chk_vec("reset_state", vec_a, {14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd13});
    clr = 1'b1;

    // brzr taken
    run_a(mk_ir(5'b10010, 4'd5, 2'b00), 32'd0, 32, dn, il, zc, ic, rc);
    chk_int("brzr_done_clock", dn, 29);
    chk_int("brzr_zlo_pc_in_cycles", zc, 4);
    chk_int("brzr_inc_pc_pulses", ic, 1);
    chk_int("brzr_r_out_cycles", rc, 4);
    chk_int("brzr_con_ff", int'(a_con_ff), 1);

    // brnz not taken
    run_a(mk_ir(5'b10010, 4'd2, 2'b01), 32'd0, 32, dn, il, zc, ic, rc);
    chk_int("brnz_done_clock", dn, 29);
    chk_int("brnz_zlo_cycles", zc, 0);
    chk_int("brnz_con_ff", int'(a_con_ff), 0);

    // brpl / brmi on a negative operand
    run_a(mk_ir(5'b10010, 4'd9, 2'b10), 32'h8000_0000, 32, dn, il, zc, ic, rc);
    chk_int("brpl_con_ff", int'(a_con_ff), 0);
    run_a(mk_ir(5'b10010, 4'd15, 2'b11), 32'h8000_0000, 32, dn, il, zc, ic, rc);
    chk_int("brmi_con_ff", int'(a_con_ff), 1);
    chk_int("brmi_zlo_cycles", zc, 4);

    // illegal opcode: abort after T2, CON FF keeps its value
    run_a(mk_ir(5'b00011, 4'd7, 2'b01), 32'd0, 20, dn, il, zc, ic, rc);
    chk_int("illegal_pulse_clock", il, 13);
    chk_int("illegal_no_done", dn, -1);
    chk_int("illegal_no_r_out", rc, 0);
    chk_int("illegal_busy_low", int'(a_busy), 0);
    chk_int("illegal_con_ff_kept", int'(a_con_ff), 1);

    // asynchronous reset in the middle of T4
    ir = mk_ir(5'b10010, 4'd3, 2'b00);
    bus_in = 32'd0;
    @(negedge clock);
    start_a = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clock);
      start_a = 1'b0;
    end
    chk_int("pre_reset_in_t4_y_in", int'(a_y_in), 1);
    #2 clr = 1'b0;
    #1 chk_vec("async_reset_mid_t4", vec_a, {14'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd13});
    @(negedge clock);
    clr = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      dcnt += int'(a_done | a_illegal);
    end
    chk_int("no_done_after_reset", dcnt, 0);

    // STEP_CYCLES=1 back-to-back with start held high
    ir = mk_ir(5'b10010, 4'd1, 2'b00);
    bus_in = 32'd0;
    @(negedge clock);
    start_b = 1'b1;
    dcnt = 0; icnt = 0; first_done = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 40) start_b = 1'b0;
      if (b_done && first_done < 0) first_done = n;
      dcnt += int'(b_done);
      icnt += int'(b_inc_pc);
    end
    chk_int("b2b_first_done", first_done, 8);
    chk_int("b2b_done_count", dcnt, 5);
    chk_int("b2b_inc_pc_count", icnt, 5);
    repeat (10) @(negedge clock);
    chk_int("b2b_idle_after", int'(b_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
